cdc_toggle_sender: RTL and testbench
====================================

CDC_TOGGLE_SENDER -- requirements
Module: cdc_toggle_sender

Interface
REQ-001 Parameter WIDTH, default 8: width of the transferred data word.
REQ-002 Parameter CNT_WIDTH, default 8: width of the dropped-request counter.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 req  input  1: one-cycle transfer request strobe.
REQ-006 req_data  input  WIDTH: word to transfer, sampled with req.
REQ-007 ack_toggle  input  1: feedback toggle returned by the receiving domain; asynchronous to clk.
REQ-008 toggle  output  1: request toggle sent to the receiving domain; registered.
REQ-009 data_out  output  WIDTH: held transfer word; registered, stable while busy.
REQ-010 busy  output  1: transfer outstanding.
REQ-011 done  output  1: one-cycle pulse when an outstanding transfer is acknowledged.
REQ-012 dropped  output  1: one-cycle pulse when a req is rejected.
REQ-013 drop_count  output  CNT_WIDTH: saturating count of rejected requests.

Function
REQ-014 ack_toggle SHALL pass through an internal two-flop synchronizer (ack_s1 -> ack_s2) before any use; no logic SHALL read ack_toggle or ack_s1 directly.
REQ-015 FSM states SHALL be IDLE and WAIT_ACK; busy SHALL be 1 exactly when the state is WAIT_ACK.
REQ-016 IDLE with req=1: at that edge toggle inverts, data_out loads req_data, state goes to WAIT_ACK; toggle and busy change on the edge that samples req (latency 1).
REQ-017 IDLE with req=0: all registers hold; done=0, dropped=0.
REQ-018 Acknowledge condition SHALL be state==WAIT_ACK and ack_s2==toggle.
REQ-019 On acknowledge without req: state goes to IDLE, and done is 1 for exactly the following cycle.
REQ-020 On acknowledge with req=1 in the same cycle: the request is accepted (toggle inverts, data_out loads req_data, state stays WAIT_ACK), done pulses, and dropped stays 0.
REQ-021 WAIT_ACK with req=1 and no acknowledge: the request is discarded, toggle and data_out hold, dropped is 1 for the following cycle, and drop_count increments.
REQ-022 drop_count SHALL saturate at 2^CNT_WIDTH-1; dropped still pulses when the count is saturated.
REQ-023 data_out SHALL not change while in WAIT_ACK except per REQ-020.
REQ-024 done, dropped, busy and toggle SHALL be registered outputs, with no combinational path from any input.
REQ-025 If ack_toggle changes at edge E, the earliest done SHALL be high after edge E+3 (E+1: ack_s1, E+2: ack_s2, E+3: FSM).
REQ-026 In IDLE, ack_s2 != toggle (spurious feedback) SHALL be ignored: no done, no state change.

Reset
REQ-027 rst=1 SHALL immediately force toggle=0, data_out=0, busy=0, done=0, dropped=0, drop_count=0, ack_s1=0, ack_s2=0, state=IDLE.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; the receiver is reset by the same rst, so toggle phases realign at 0.
REQ-029 The first req accepted after rst deassertion SHALL behave per REQ-016.

Verification
REQ-030 Single transfer: req=1 with req_data=0xA5 for 1 cycle; loop toggle back to ack_toggle through a 2-cycle delay -> toggle goes 0->1, data_out=0xA5, busy=1, then done is one cycle high 3 edges after ack_toggle rises, then busy=0.
REQ-031 Drop: during WAIT_ACK, 3 req pulses with data 0x11/0x22/0x33 -> 3 dropped pulses, drop_count=3, data_out stays 0xA5.
REQ-032 Back-to-back: req=1 with data 0x5A in the acknowledge cycle -> done=1, dropped=0, toggle inverts again, data_out=0x5A, busy stays 1.
REQ-033 Saturation: CNT_WIDTH=2, 5 drops -> drop_count sequence 1,2,3,3,3; dropped pulses 5 times.
REQ-034 Reset mid-transfer: rst pulse while busy=1 -> all outputs 0 within the reset cycle, no done pulse; a following transfer with data 0x3C completes normally.
REQ-035 Spurious ack: in IDLE, toggle ack_toggle -> no done, busy=0, state IDLE.

Source files
------------

// File: rtl/cdc_toggle_sender_if.sv
// rtl/cdc_toggle_sender_if.sv - request/ack toggle bundle between the sender and its environment
interface cdc_toggle_sender_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
);
   logic                 req;
   logic [WIDTH-1:0]     req_data;
   logic                 ack_toggle;
   logic                 toggle;
   logic [WIDTH-1:0]     data_out;
   logic                 busy;
   logic                 done;
   logic                 dropped;
   logic [CNT_WIDTH-1:0] drop_count;

   // Environment side: issues requests and returns the receiver feedback toggle
   modport master (
      output req, req_data, ack_toggle,
      input  toggle, data_out, busy, done, dropped, drop_count
   );

   // Sender side
   modport slave (
      input  req, req_data, ack_toggle,
      output toggle, data_out, busy, done, dropped, drop_count
   );
endinterface

// File: rtl/cdc_toggle_sender.sv
// rtl/cdc_toggle_sender.sv - toggle-handshake sender with synchronized ack and saturating drop counter
module cdc_toggle_sender #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   cdc_toggle_sender_if.slave    bus
);
   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic                 ack_s1;
   logic                 ack_s2;
   logic                 toggle_q;
   logic [WIDTH-1:0]     data_q;
   logic                 done_q;
   logic                 dropped_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 ack_hit;
   logic                 accept;
   logic                 reject;

   // Two-flop synchronizer for the feedback toggle; only ack_s2 is used downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= bus.ack_toggle;
         ack_s2 <= ack_s1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state: a request issued in the ack cycle keeps the FSM waiting on the new phase
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (bus.req) state_nx = WAIT_ACK;
         WAIT_ACK: if (ack_hit) state_nx = bus.req ? WAIT_ACK : IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Decode acknowledge, acceptance and rejection for this cycle
   always_comb begin
      ack_hit = (state == WAIT_ACK) && (ack_s2 == toggle_q);
      accept  = bus.req && ((state == IDLE) || ack_hit);
      reject  = bus.req && (state == WAIT_ACK) && !ack_hit;
   end

   // Registered outputs: toggle, held word, pulses and the saturating drop count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle_q  <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         done_q    <= ack_hit;
         dropped_q <= reject;
         if (accept) begin
            toggle_q <= ~toggle_q;
            data_q   <= bus.req_data;
         end
         if (reject && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.toggle     = toggle_q;
   assign bus.data_out   = data_q;
   assign bus.busy       = (state == WAIT_ACK);
   assign bus.done       = done_q;
   assign bus.dropped    = dropped_q;
   assign bus.drop_count = cnt_q;
endmodule

// File: tb/tb_cdc_toggle_sender.sv
// tb/tb_cdc_toggle_sender.sv - scoreboard bench for cdc_toggle_sender
module tb_cdc_toggle_sender;
   logic clk = 1'b0;
   logic rst = 1'b1;

   cdc_toggle_sender_if #(.WIDTH(8), .CNT_WIDTH(2)) sif ();

   cdc_toggle_sender #(.WIDTH(8), .CNT_WIDTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;

   int         n_pass = 0;
   int         n_total = 0;
   int         done_seen = 0;
   logic [7:0] exp_data_q[$];
   logic [1:0] exp_cnt_q[$];
   logic       prev_tog = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every toggle edge pops the expected held word, every drop pulse pops the expected count
   always @(negedge clk) begin
      if (rst) begin
         prev_tog = 1'b0;
      end else begin
         if (sif.toggle !== prev_tog) begin
            prev_tog = sif.toggle;
            n_total++;
            if (exp_data_q.size() == 0)
               $display("FAIL sb_data: unexpected transfer data_out=%0h, none expected", sif.data_out);
            else begin
               logic [7:0] e;
               e = exp_data_q.pop_front();
               if (sif.data_out !== e) $display("FAIL sb_data: data_out=%0h expected %0h", sif.data_out, e);
               else n_pass++;
            end
         end
         if (sif.done === 1'b1) done_seen++;
         if (sif.dropped === 1'b1) begin
            n_total++;
            if (exp_cnt_q.size() == 0)
               $display("FAIL sb_drop: unexpected drop pulse count=%0d", sif.drop_count);
            else begin
               logic [1:0] c;
               c = exp_cnt_q.pop_front();
               if (sif.drop_count !== c) $display("FAIL sb_drop: drop_count=%0d expected %0d", sif.drop_count, c);
               else n_pass++;
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      sif.req = 1'b0;
      sif.req_data = 8'h00;
      sif.ack_toggle = 1'b0;
      step();
      step();
      n_total++; if (sif.toggle !== 1'b0) $display("FAIL rst_toggle: got %b expected 0", sif.toggle); else n_pass++;
      n_total++; if (sif.data_out !== 8'h00) $display("FAIL rst_data: got %0h expected 0", sif.data_out); else n_pass++;
      n_total++; if (sif.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", sif.busy); else n_pass++;
      n_total++; if ({sif.done, sif.dropped} !== 2'b00) $display("FAIL rst_pulses: got %b expected 00", {sif.done, sif.dropped}); else n_pass++;
      n_total++; if (sif.drop_count !== 2'd0) $display("FAIL rst_cnt: got %0d expected 0", sif.drop_count); else n_pass++;
      rst = 1'b0;
      step();
      n_total++; if (sif.busy !== 1'b0) $display("FAIL post_rst_busy: got %b expected 0", sif.busy); else n_pass++;
   endtask

   task automatic test_single();
      sif.req = 1'b1;
      sif.req_data = 8'hA5;
      exp_data_q.push_back(8'hA5);
      step();
      sif.req = 1'b0;
      n_total++; if (sif.toggle !== 1'b1) $display("FAIL single_toggle: got %b expected 1", sif.toggle); else n_pass++;
      n_total++; if (sif.busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", sif.busy); else n_pass++;
      n_total++; if (sif.data_out !== 8'hA5) $display("FAIL single_data: got %0h expected a5", sif.data_out); else n_pass++;
      step();
      sif.ack_toggle = 1'b1;
      step();
      n_total++; if (sif.done !== 1'b0) $display("FAIL single_done_e1: got %b expected 0", sif.done); else n_pass++;
      step();
      n_total++; if (sif.done !== 1'b0 || sif.busy !== 1'b1) $display("FAIL single_e2: done/busy=%b%b expected 01", sif.done, sif.busy); else n_pass++;
      step();
      n_total++; if (sif.done !== 1'b1) $display("FAIL single_done_e3: got %b expected 1", sif.done); else n_pass++;
      n_total++; if (sif.busy !== 1'b0) $display("FAIL single_busy_end: got %b expected 0", sif.busy); else n_pass++;
      step();
      n_total++; if (sif.done !== 1'b0) $display("FAIL single_done_width: got %b expected 0", sif.done); else n_pass++;
   endtask

   task automatic test_drop();
      logic [7:0] d [3];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      sif.req = 1'b1;
      sif.req_data = 8'hA5;
      exp_data_q.push_back(8'hA5);
      step();
      sif.req = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         sif.req = 1'b1;
         sif.req_data = d[i];
         exp_cnt_q.push_back(2'(i + 1));
         step();
         sif.req = 1'b0;
         n_total++; if (sif.dropped !== 1'b1) $display("FAIL drop_pulse%0d: got %b expected 1", i, sif.dropped); else n_pass++;
         step();
         n_total++; if (sif.dropped !== 1'b0) $display("FAIL drop_clear%0d: got %b expected 0", i, sif.dropped); else n_pass++;
      end
      n_total++; if (sif.drop_count !== 2'd3) $display("FAIL drop_count: got %0d expected 3", sif.drop_count); else n_pass++;
      n_total++; if (sif.data_out !== 8'hA5 || sif.toggle !== 1'b0) $display("FAIL drop_hold: data=%0h toggle=%b expected a5/0", sif.data_out, sif.toggle); else n_pass++;
   endtask

   task automatic test_back_to_back();
      sif.ack_toggle = 1'b0;
      step();
      step();
      sif.req = 1'b1;
      sif.req_data = 8'h5A;
      exp_data_q.push_back(8'h5A);
      step();
      sif.req = 1'b0;
      n_total++; if (sif.done !== 1'b1 || sif.dropped !== 1'b0) $display("FAIL b2b_pulses: done/dropped=%b%b expected 10", sif.done, sif.dropped); else n_pass++;
      n_total++; if (sif.toggle !== 1'b1 || sif.busy !== 1'b1) $display("FAIL b2b_state: toggle/busy=%b%b expected 11", sif.toggle, sif.busy); else n_pass++;
      n_total++; if (sif.data_out !== 8'h5A) $display("FAIL b2b_data: got %0h expected 5a", sif.data_out); else n_pass++;
      sif.ack_toggle = 1'b1;
      step();
      step();
      step();
      n_total++; if (sif.done !== 1'b1 || sif.busy !== 1'b0) $display("FAIL b2b_finish: done/busy=%b%b expected 10", sif.done, sif.busy); else n_pass++;
      step();
   endtask

   task automatic test_saturation();
      logic [1:0] exp_c [5];
      exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
      rst = 1'b1;
      sif.ack_toggle = 1'b0;
      step();
      rst = 1'b0;
      step();
      sif.req = 1'b1;
      sif.req_data = 8'h77;
      exp_data_q.push_back(8'h77);
      step();
      for (int i = 0; i < 5; i++) begin
         sif.req_data = 8'(8'h80 + i);
         exp_cnt_q.push_back(exp_c[i]);
         step();
         n_total++; if (sif.dropped !== 1'b1 || sif.drop_count !== exp_c[i])
            $display("FAIL sat_%0d: dropped=%b count=%0d expected 1/%0d", i, sif.dropped, sif.drop_count, exp_c[i]);
         else n_pass++;
      end
      sif.req = 1'b0;
      step();
      n_total++; if (sif.data_out !== 8'h77) $display("FAIL sat_hold: got %0h expected 77", sif.data_out); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int d0;
      n_total++; if (sif.busy !== 1'b1) $display("FAIL mid_pre_busy: got %b expected 1", sif.busy); else n_pass++;
      d0 = done_seen;
      rst = 1'b1;
      #1;
      n_total++; if ({sif.toggle, sif.busy, sif.done, sif.dropped} !== 4'b0000 || sif.data_out !== 8'h00 || sif.drop_count !== 2'd0)
         $display("FAIL mid_rst_outputs: tog/busy/done/drop=%b%b%b%b data=%0h cnt=%0d expected all 0",
                  sif.toggle, sif.busy, sif.done, sif.dropped, sif.data_out, sif.drop_count);
      else n_pass++;
      step();
      rst = 1'b0;
      sif.ack_toggle = 1'b0;
      step();
      step();
      n_total++; if (done_seen !== d0) $display("FAIL mid_no_done: done pulses %0d expected %0d", done_seen - d0, 0); else n_pass++;
      sif.req = 1'b1;
      sif.req_data = 8'h3C;
      exp_data_q.push_back(8'h3C);
      step();
      sif.req = 1'b0;
      n_total++; if (sif.toggle !== 1'b1 || sif.data_out !== 8'h3C) $display("FAIL mid_restart: toggle=%b data=%0h expected 1/3c", sif.toggle, sif.data_out); else n_pass++;
      step();
      sif.ack_toggle = 1'b1;
      step();
      step();
      step();
      n_total++; if (sif.done !== 1'b1 || sif.busy !== 1'b0) $display("FAIL mid_complete: done/busy=%b%b expected 10", sif.done, sif.busy); else n_pass++;
      step();
   endtask

   task automatic test_spurious();
      sif.ack_toggle = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_total++; if (sif.done !== 1'b0 || sif.busy !== 1'b0) $display("FAIL spur_%0d: done/busy=%b%b expected 00", i, sif.done, sif.busy); else n_pass++;
      end
      n_total++; if (sif.toggle !== 1'b1) $display("FAIL spur_toggle: got %b expected 1", sif.toggle); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_drop();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      test_spurious();
      step();
      n_total++; if (done_seen != 4) $display("FAIL done_total: got %0d expected 4", done_seen); else n_pass++;
      n_total++; if (exp_data_q.size() != 0) $display("FAIL sb_data_left: got %0d expected 0", exp_data_q.size()); else n_pass++;
      n_total++; if (exp_cnt_q.size() != 0) $display("FAIL sb_drop_left: got %0d expected 0", exp_cnt_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
